// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package mc_control_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BR  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SLL = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SRL = 3'b101;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b111;

  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE = 3'b101;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;
  localparam logic [SEL_W-1:0] IMM_I      = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S      = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B      = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J      = 2'b11;

  // Per-state control word driven by the FSM.
  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic [SEL_W-1:0] srca;
    logic [SEL_W-1:0] srcb;
    logic [SEL_W-1:0] res;
    logic             adr;
    logic             irw;
    logic             pcw;
    logic             rw;
    logic             mw;
    logic             halted;
  } ctrl_t;

  function automatic logic [SEL_W-1:0] imm_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_alu_dec.sv
// ALU operation decode from funct3/funct7b5; flags funct3 codes with no ALU op.
module mc_control_alu_dec
  import mc_control_pkg::*;
(
  input  logic [F3_W-1:0]  funct3,
  input  logic             funct7b5,
  input  logic             is_r,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct3)
      3'b000:  alu_control = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b100:  alu_control = ALU_XOR;
      3'b101:  alu_control = ALU_SRL;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM. Define SIGNED_BRANCH_EN to decode blt/bge;
// otherwise those branches halt and SF is ignored.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  Opcode,
  input  logic [F3_W-1:0]  Funct3,
  input  logic             Funct7b5,
  input  logic             ZF,
  input  logic             SF,
  output logic [ALU_W-1:0] ALUControl,
  output logic [SEL_W-1:0] ALUSrcA,
  output logic [SEL_W-1:0] ALUSrcB,
  output logic [SEL_W-1:0] ResultSrc,
  output logic [SEL_W-1:0] ImmSrc,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             Halted
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             fetch_done;
  logic             is_r;
  logic [ALU_W-1:0] dec_alu;
  logic             alu_illegal;
  logic             br_legal, br_taken;
  ctrl_t            ctl;

  assign is_r       = (state == S_EXECR);
  assign fetch_done = (cnt == CNT_W'(FETCH_WAIT));

  mc_control_alu_dec u_alu_dec (
    .funct3      (Funct3),
    .funct7b5    (Funct7b5),
    .is_r        (is_r),
    .alu_control (dec_alu),
    .illegal     (alu_illegal)
  );

  // Branch condition select; signed compares exist only when enabled.
  always_comb begin
    br_legal = 1'b0;
    br_taken = 1'b0;
    case (Funct3)
      F3_BEQ: begin br_legal = 1'b1; br_taken = ZF;  end
      F3_BNE: begin br_legal = 1'b1; br_taken = !ZF; end
`ifdef SIGNED_BRANCH_EN
      F3_BLT: begin br_legal = 1'b1; br_taken = SF;  end
      F3_BGE: begin br_legal = 1'b1; br_taken = !SF; end
`endif
      default: ;
    endcase
  end

`ifndef SIGNED_BRANCH_EN
  logic unused_sf;
  assign unused_sf = SF;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctl       = '0;
    case (state)
      S_FETCH: begin
        ctl.srcb = SRCB_FOUR;
        ctl.res  = RES_ALURES;
        if (fetch_done) begin
          ctl.irw   = 1'b1;
          ctl.pcw   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_DECODE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        ctl.srca = SRCA_OLDPC;
        ctl.srcb = SRCB_IMM;
        case (Opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = alu_illegal ? S_HALT : S_EXECR;
          OP_I:         state_nxt = alu_illegal ? S_HALT : S_EXECI;
          OP_BR:        state_nxt = br_legal ? S_BRANCH : S_HALT;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ctl.srca  = SRCA_RS1;
        ctl.srcb  = SRCB_IMM;
        state_nxt = Opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctl.adr   = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.res   = RES_MEM;
        ctl.rw    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        ctl.adr   = 1'b1;
        ctl.mw    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EXECR: begin
        ctl.srca  = SRCA_RS1;
        ctl.srcb  = SRCB_RS2;
        ctl.alu   = dec_alu;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ctl.srca  = SRCA_RS1;
        ctl.srcb  = SRCB_IMM;
        ctl.alu   = dec_alu;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.rw    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ctl.srca  = SRCA_RS1;
        ctl.srcb  = SRCB_RS2;
        ctl.alu   = ALU_SUB;
        ctl.res   = RES_ALUOUT;
        ctl.pcw   = br_taken;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        ctl.srca  = SRCA_OLDPC;
        ctl.srcb  = SRCB_FOUR;
        ctl.res   = RES_ALUOUT;
        ctl.pcw   = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_HALT: ctl.halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
    // Nothing may write architectural state while reset is being applied.
    if (!rst_n) begin
      ctl.irw = 1'b0;
      ctl.pcw = 1'b0;
      ctl.rw  = 1'b0;
      ctl.mw  = 1'b0;
    end
  end

  assign ALUControl = ctl.alu;
  assign ALUSrcA    = ctl.srca;
  assign ALUSrcB    = ctl.srcb;
  assign ResultSrc  = ctl.res;
  assign AdrSrc     = ctl.adr;
  assign IRWrite    = ctl.irw;
  assign PCWrite    = ctl.pcw;
  assign RegWrite   = ctl.rw;
  assign MemWrite   = ctl.mw;
  assign Halted     = ctl.halted;
  assign ImmSrc     = imm_sel(Opcode);

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: one instance with FETCH_WAIT=0 and one with FETCH_WAIT=2,
// each checked cycle by cycle against per-instruction step scripts.
module tb_mc_control;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       hlt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic [6:0] opc [2];
  logic [2:0] f3  [2];
  logic       f7  [2];
  logic       zf  [2];
  logic       sf  [2];
  logic [2:0] aluc[2];
  logic [1:0] sa  [2];
  logic [1:0] sb  [2];
  logic [1:0] rs  [2];
  logic [1:0] imm [2];
  logic       adr [2];
  logic       irw [2];
  logic       pcw [2];
  logic       rw  [2];
  logic       mw  [2];
  logic       hlt [2];

  mc_control #(.FETCH_WAIT(0)) u0 (
    .clk(clk), .rst_n(rst[0]), .Opcode(opc[0]), .Funct3(f3[0]), .Funct7b5(f7[0]),
    .ZF(zf[0]), .SF(sf[0]), .ALUControl(aluc[0]), .ALUSrcA(sa[0]), .ALUSrcB(sb[0]),
    .ResultSrc(rs[0]), .ImmSrc(imm[0]), .AdrSrc(adr[0]), .IRWrite(irw[0]),
    .PCWrite(pcw[0]), .RegWrite(rw[0]), .MemWrite(mw[0]), .Halted(hlt[0])
  );

  mc_control #(.FETCH_WAIT(2)) u1 (
    .clk(clk), .rst_n(rst[1]), .Opcode(opc[1]), .Funct3(f3[1]), .Funct7b5(f7[1]),
    .ZF(zf[1]), .SF(sf[1]), .ALUControl(aluc[1]), .ALUSrcA(sa[1]), .ALUSrcB(sb[1]),
    .ResultSrc(rs[1]), .ImmSrc(imm[1]), .AdrSrc(adr[1]), .IRWrite(irw[1]),
    .PCWrite(pcw[1]), .RegWrite(rw[1]), .MemWrite(mw[1]), .Halted(hlt[1])
  );

  int   tests = 0;
  int   fails = 0;
  vec_t q0[$], q1[$], h0[$], h1[$];

  function automatic vec_t mk(input logic [2:0] a, input logic [1:0] s_a, input logic [1:0] s_b,
                              input logic [1:0] r, input logic ad, input logic ir, input logic pc,
                              input logic r_w, input logic m_w, input logic h);
    return {a, s_a, s_b, r, ad, ir, pc, r_w, m_w, h};
  endfunction

  // Expected outputs of each step an instruction walks through.
  function automatic vec_t v_fetch(input logic last); return mk(3'd0, 2'd0, 2'd2, 2'd2, 0, last, last, 0, 0, 0); endfunction
  function automatic vec_t v_dec();          return mk(3'd0, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic vec_t v_madr();         return mk(3'd0, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic vec_t v_mrd();          return mk(3'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic vec_t v_mwb();          return mk(3'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 1, 0, 0); endfunction
  function automatic vec_t v_mwr();          return mk(3'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 1, 0); endfunction
  function automatic vec_t v_exr(input logic [2:0] a); return mk(a, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic vec_t v_exi(input logic [2:0] a); return mk(a, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic vec_t v_awb();          return mk(3'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0); endfunction
  function automatic vec_t v_br(input logic t); return mk(3'd2, 2'd2, 2'd0, 2'd0, 0, 0, t, 0, 0, 0); endfunction
  function automatic vec_t v_jal();          return mk(3'd0, 2'd1, 2'd2, 2'd0, 0, 0, 1, 0, 0, 0); endfunction
  function automatic vec_t v_halt();         return mk(3'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1); endfunction

  function automatic logic [2:0] alu_ref(input logic [2:0] f, input logic b7, input logic isr);
    case (f)
      3'd0:    return (isr && b7) ? 3'd2 : 3'd0;
      3'd1:    return 3'd1;
      3'd4:    return 3'd4;
      3'd5:    return 3'd5;
      3'd6:    return 3'd6;
      3'd7:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit alu_legal(input logic [2:0] f);
    return (f != 3'd2) && (f != 3'd3);
  endfunction

  function automatic bit br_legal(input logic [2:0] f);
`ifdef SIGNED_BRANCH_EN
    return (f == 3'd0) || (f == 3'd1) || (f == 3'd4) || (f == 3'd5);
`else
    return (f == 3'd0) || (f == 3'd1);
`endif
  endfunction

  function automatic logic br_taken(input logic [2:0] f, input logic z, input logic s);
    case (f)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return s;
      3'd5:    return !s;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 2'd1;
    if (o == 7'b1100011) return 2'd2;
    if (o == 7'b1101111) return 2'd3;
    return 2'd0;
  endfunction

  function automatic vec_t act(input int d);
    return {aluc[d], sa[d], sb[d], rs[d], adr[d], irw[d], pcw[d], rw[d], mw[d], hlt[d]};
  endfunction

  // Count of cycles in the recorded history with a given strobe high (0 irw, 1 mw, 2 rw, 3 hlt).
  function automatic int cnt_bits(input int d, input int f);
    int   c;
    int   n;
    vec_t v;
    c = 0;
    n = (d == 0) ? h0.size() : h1.size();
    for (int i = 0; i < n; i++) begin
      v = (d == 0) ? h0[i] : h1[i];
      case (f)
        0:       c += int'(v.irw);
        1:       c += int'(v.mw);
        2:       c += int'(v.rw);
        default: c += int'(v.hlt);
      endcase
    end
    return c;
  endfunction

  // Per-cycle comparison against the expected-step queues.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      vec_t e;
      vec_t a;
      bit   have;
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (have) begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        a = act(d);
        if (d == 0) h0.push_back(a); else h1.push_back(a);
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL ctrl_vec dut%0d t=%0t: got %h expected %h", d, $time, a, e);
        end
        tests++;
        if (imm[d] !== imm_ref(opc[d])) begin
          fails++;
          $display("FAIL immsrc dut%0d t=%0t: got %0d expected %0d", d, $time, imm[d], imm_ref(opc[d]));
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input int d, input vec_t v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 200);
    if (((d == 0) ? q0.size() : q1.size()) != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", d,
               (d == 0) ? q0.size() : q1.size());
      if (d == 0) q0.delete(); else q1.delete();
    end
  endtask

  // Holds the instruction on the inputs for its whole life; keep>0 truncates the script.
  task automatic run(input int d, input logic [6:0] o, input logic [2:0] fn3, input logic b7,
                     input logic z, input logic s, input int keep, output int lat, output bit halted);
    vec_t seq[$];
    int   fw;
    fw = (d == 0) ? 0 : 2;
    opc[d] = o; f3[d] = fn3; f7[d] = b7; zf[d] = z; sf[d] = s;
    halted = 1'b0;
    for (int i = 0; i <= fw; i++) seq.push_back(v_fetch(i == fw));
    seq.push_back(v_dec());
    case (o)
      7'b0000011: begin seq.push_back(v_madr()); seq.push_back(v_mrd()); seq.push_back(v_mwb()); end
      7'b0100011: begin seq.push_back(v_madr()); seq.push_back(v_mwr()); end
      7'b0110011:
        if (alu_legal(fn3)) begin seq.push_back(v_exr(alu_ref(fn3, b7, 1'b1))); seq.push_back(v_awb()); end
        else halted = 1'b1;
      7'b0010011:
        if (alu_legal(fn3)) begin seq.push_back(v_exi(alu_ref(fn3, b7, 1'b0))); seq.push_back(v_awb()); end
        else halted = 1'b1;
      7'b1100011:
        if (br_legal(fn3)) seq.push_back(v_br(br_taken(fn3, z, s)));
        else halted = 1'b1;
      7'b1101111: begin seq.push_back(v_jal()); seq.push_back(v_awb()); end
      default: halted = 1'b1;
    endcase
    lat = seq.size();
    if (halted) for (int i = 0; i < 10; i++) seq.push_back(v_halt());
    if (d == 0) h0.delete(); else h1.delete();
    for (int i = 0; i < seq.size() && (keep == 0 || i < keep); i++) push(d, seq[i]);
    drain(d);
  endtask

  // Reset asserted for two edges: the held cycle keeps its state, then FETCH with strobes off.
  task automatic do_reset(input int d, input vec_t held);
    rst[d] = 1'b0;
    push(d, held);
    drain(d);
    push(d, v_fetch(1'b0));
    drain(d);
    rst[d] = 1'b1;
  endtask

  initial begin
    int lat;
    bit h;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; opc[d] = '0; f3[d] = '0; f7[d] = 1'b0; zf[d] = 1'b0; sf[d] = 1'b0;
    end
    @(posedge clk);
    #1;

    // ---- FETCH_WAIT = 0 ----
    h0.delete();
    push(0, v_fetch(1'b0));
    drain(0);
    chk("rst_irwrite", int'(h0[0].irw), 0);
    chk("rst_halted", int'(h0[0].hlt), 0);
    rst[0] = 1'b1;

    run(0, 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("add_latency", lat, 4);
    chk("add_fetch_irw", int'(h0[0].irw), 1);
    chk("add_exec_alu", int'(h0[2].alu), 0);
    chk("add_wb_regwrite", int'(h0[3].rw), 1);

    run(0, 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0, lat, h);
    chk("sub_exec_alu", int'(h0[2].alu), 2);

    run(0, 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 0, lat, h);
    chk("addi_exec_alu", int'(h0[2].alu), 0);
    chk("addi_srcb", int'(h0[2].sb), 1);

    run(0, 7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 0, lat, h);
    run(0, 7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0, 0, lat, h);
    run(0, 7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 0, lat, h);

    run(0, 7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, lat, h);
    chk("beq_latency", lat, 3);
    chk("beq_taken_pcw", int'(h0[2].pcw), 1);
    run(0, 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("beq_not_taken_pcw", int'(h0[2].pcw), 0);
    run(0, 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 0, lat, h);

    run(0, 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("jal_latency", lat, 4);
    chk("jal_pcw", int'(h0[2].pcw), 1);
    chk("jal_wb_regwrite", int'(h0[3].rw), 1);

    run(0, 7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 0, lat, h);
`ifdef SIGNED_BRANCH_EN
    chk("blt_taken_pcw", int'(h0[2].pcw), 1);
`else
    chk("blt_halt_cycles", cnt_bits(0, 3), 10);
    do_reset(0, v_halt());
`endif

    run(0, 7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("slt_halt_cycles", cnt_bits(0, 3), 10);
    do_reset(0, v_halt());

    run(0, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("op0_halt_cycles", cnt_bits(0, 3), 10);
    chk("op0_halt_no_strobe", cnt_bits(0, 0) + cnt_bits(0, 1) + cnt_bits(0, 2), 1);
    do_reset(0, v_halt());
    run(0, 7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("post_halt_or_wb", int'(h0[3].rw), 1);

    // ---- FETCH_WAIT = 2 ----
    h1.delete();
    push(1, v_fetch(1'b0));
    drain(1);
    chk("rst1_irwrite", int'(h1[0].irw), 0);
    rst[1] = 1'b1;

    run(1, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("lw_latency", lat, 7);
    chk("lw_fetch0_irw", int'(h1[0].irw), 0);
    chk("lw_fetch1_irw", int'(h1[1].irw), 0);
    chk("lw_fetch2_irw", int'(h1[2].irw), 1);
    chk("lw_irw_pulses", cnt_bits(1, 0), 1);
    chk("lw_memwb_result", int'(h1[6].rs), 1);
    chk("lw_no_memwrite", cnt_bits(1, 1), 0);

    run(1, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("sw_latency", lat, 6);
    chk("sw_memwrite_cycle", int'(h1[5].mw), 1);
    chk("sw_memwrite_pulses", cnt_bits(1, 1), 1);

    run(1, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 5, lat, h);
    do_reset(1, v_mrd());
    chk("memread_reset_no_regwrite", cnt_bits(1, 2), 0);
    run(1, 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, lat, h);
    chk("post_reset_add_wb", int'(h1[5].rw), 1);
    chk("post_reset_irw_third", int'(h1[2].irw), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: FETCH_WAIT, default 0, number of extra wait cycles spent in FETCH before the instruction is latched (0..7).
REQ-002 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 Opcode  in  7  instr[6:0].
REQ-005 Funct3  in  3  instr[14:12].
REQ-006 Funct7b5  in  1  instr[30].
REQ-007 ZF  in  1  ALU zero flag; SF  in  1  ALU sign flag (ALUResult[31]).
REQ-008 ALUControl  out  3  ALU op: 000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and.
REQ-009 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1; ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4.
REQ-010 ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALUResult.
REQ-011 ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; combinational from Opcode.
REQ-012 AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Halted  out  1 each  strobes/status.

Function
REQ-013 Registered Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT; all outputs except ImmSrc and PCWrite in BRANCH are functions of state only.
REQ-014 Outputs not listed for a state: strobes 0, selects 00, ALUControl 000.
REQ-015 FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10; wait counter counts 0..FETCH_WAIT; IRWrite=PCWrite=1 only in the cycle counter==FETCH_WAIT, then go to DECODE.
REQ-016 DECODE: ALUSrcA 01, ALUSrcB 01, add; next: lw 0000011/sw 0100011 -> MEMADR, R 0110011 -> EXECR, I-ALU 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, any other -> HALT.
REQ-017 MEMADR: ALUSrcA 10, ALUSrcB 01, add; -> MEMREAD if Opcode[5]=0 else MEMWRITE.
REQ-018 MEMREAD: AdrSrc 1 -> MEMWB; MEMWB: ResultSrc 01, RegWrite 1 -> FETCH; MEMWRITE: AdrSrc 1, MemWrite 1 -> FETCH.
REQ-019 EXECR: ALUSrcA 10, ALUSrcB 00; EXECI: ALUSrcA 10, ALUSrcB 01; both -> ALUWB; ALUWB: RegWrite 1 -> FETCH.
REQ-020 ALU decode by Funct3: 000 add (sub only in EXECR with Funct7b5=1), 001 sll, 100 xor, 101 srl, 110 or, 111 and; 010, 011 are illegal: DECODE goes to HALT.
REQ-021 BRANCH: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00; PCWrite = taken, where 000 beq ZF, 001 bne !ZF, 100 blt SF, 101 bge !SF; other Funct3 -> HALT from DECODE; -> FETCH.
REQ-022 JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1 -> ALUWB.
REQ-023 HALT: Halted 1, all strobes 0, remains until reset.
REQ-024 Latency: lw 5, sw 4, R/I 4, branch 3, jal 4 cycles, each plus FETCH_WAIT.

Reset
REQ-025 rst_n=0 at a rising edge forces FETCH, wait counter 0, Halted 0, from any state including mid-instruction and HALT; no strobe is asserted in the reset cycle.
REQ-026 First FETCH cycle after reset release counts as wait count 0.

Configuration
REQ-027 Macro SIGNED_BRANCH_EN: defined -> blt/bge decoded per REQ-021; undefined -> Funct3 100/101 branches go to HALT, SF unused.

Structure
REQ-028 Shared package holds state enum, ALUControl op codes, opcode constants, ALUSrcA/B, ResultSrc and ImmSrc encodings.
REQ-029 One sub-module alu_dec (Funct3, Funct7b5, isR -> ALUControl, illegal) is natural; FSM stays in mc_control.

Verification
REQ-030 Reset then add (0110011, f3 000, f7b5 0), FETCH_WAIT=0 -> FETCH, DECODE, EXECR (ALUControl 000), ALUWB (RegWrite 1), FETCH: 4 cycles.
REQ-031 sub R-type f7b5=1 -> ALUControl 010 in EXECR; addi with f7b5=1 -> ALUControl 000 in EXECI.
REQ-032 beq with ZF=1 -> PCWrite 1 in BRANCH; ZF=0 -> PCWrite 0; blt with SF=1 -> PCWrite 1 (macro defined), HALT (undefined).
REQ-033 lw then sw, FETCH_WAIT=2 -> IRWrite only on 3rd FETCH cycle; lw 7 cycles, MemWrite 1 only in MEMWRITE.
REQ-034 Opcode 0000000 -> HALT with Halted 1 held 10 cycles; rst_n=0 -> FETCH next edge; reset asserted during MEMREAD -> FETCH, no RegWrite pulse.
